// File: rtl/hazard_control_unit.sv
// hazard_control_unit
//   Pipeline hazard controller. It detects load-use hazards and inserts a
//   single bubble for them, squashes the front of the pipe on a taken
//   branch/jump, and freezes the whole pipe while data memory is busy.
//   It also keeps saturating counts of stall and flush events.
//
// Ports
//   clk                   pipeline clock, rising edge
//   arst                  asynchronous active-high reset
//   mem_read_ID_EXE       ID/EXE instruction is a load
//   regfile_waddr_ID_EXE  destination register of the ID/EXE instruction
//   instruction_IF_ID_Rs  Rs field of the IF/ID instruction
//   instruction_IF_ID_Rt  Rt field of the IF/ID instruction
//   pc_src_EXE_MEM        branch/jump taken, resolved in EXE/MEM
//   dmem_wait             data memory not ready
//   cnt_clear             synchronous clear of both counters
//   pc_write              PC write enable
//   if_id_write           IF/ID write enable
//   id_exe_bubble         zero the control bits entering ID/EXE
//   if_id_flush           squash IF/ID
//   id_exe_flush          squash ID/EXE
//   exe_mem_flush         squash EXE/MEM
//   pipe_freeze           hold ID/EXE, EXE/MEM and MEM/WB
//   hazard_state          00 RUN, 01 STALL, 10 FREEZE
//   stall_count           saturating count of bubble/freeze cycles
//   flush_count           saturating count of flush cycles
module hazard_control_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             mem_read_ID_EXE,
    input  logic [4:0]       regfile_waddr_ID_EXE,
    input  logic [4:0]       instruction_IF_ID_Rs,
    input  logic [4:0]       instruction_IF_ID_Rt,
    input  logic             pc_src_EXE_MEM,
    input  logic             dmem_wait,
    input  logic             cnt_clear,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_exe_bubble,
    output logic             if_id_flush,
    output logic             id_exe_flush,
    output logic             exe_mem_flush,
    output logic             pipe_freeze,
    output logic [1:0]       hazard_state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        STALL  = 2'b01,
        FREEZE = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state, state_nxt;
    logic   load_use;
    logic   lu_stall;

    // r0 is hard-wired to zero, so a load targeting it never creates a hazard.
    assign load_use = mem_read_ID_EXE
                   && (regfile_waddr_ID_EXE != 5'd0)
                   && ((regfile_waddr_ID_EXE == instruction_IF_ID_Rs)
                    || (regfile_waddr_ID_EXE == instruction_IF_ID_Rt));

    // Only stall from RUN: the cycle after a stall the same load has moved on,
    // so a repeated match in STALL must not stall the instruction twice.
    assign lu_stall = load_use && (state == RUN)
                   && !dmem_wait && !pc_src_EXE_MEM;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (dmem_wait) begin
            state_nxt = FREEZE;
        end else begin
            case (state)
                RUN:     state_nxt = lu_stall ? STALL : RUN;
                STALL:   state_nxt = RUN;
                FREEZE:  state_nxt = RUN;
                default: state_nxt = RUN;
            endcase
        end
    end

    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_exe_bubble = 1'b0;
        if_id_flush   = 1'b0;
        id_exe_flush  = 1'b0;
        exe_mem_flush = 1'b0;
        pipe_freeze   = 1'b0;
        if (arst) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (dmem_wait) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_freeze = 1'b1;
        end else if (pc_src_EXE_MEM) begin
            if_id_flush   = 1'b1;
            id_exe_flush  = 1'b1;
            exe_mem_flush = 1'b1;
        end else if (lu_stall) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_exe_bubble = 1'b1;
        end
    end

    assign hazard_state = state;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else if (cnt_clear) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if ((id_exe_bubble || pipe_freeze) && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (exe_mem_flush && (flush_count != CNT_MAX)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit
//   Table-driven bench for hazard_control_unit (CNT_W=4). Each vector holds
//   inputs and the expected control outputs/state; vectors are queued when
//   driven and checked on the following falling edge, with a saturating
//   counter model tracking stall_count and flush_count.
module tb_hazard_control_unit;

    localparam int CNT_W   = 4;
    localparam int CNT_SAT = 15;

    typedef struct {
        logic       mr;
        logic [4:0] waddr;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       pcsrc;
        logic       dw;
        logic       clr;
        logic       e_pcw;
        logic       e_ifw;
        logic       e_bub;
        logic       e_fl;
        logic       e_frz;
        logic [1:0] e_st;
    } vec_t;

    logic             clk = 1'b0;
    logic             arst = 1'b1;
    logic             mem_read_ID_EXE = 1'b0;
    logic [4:0]       regfile_waddr_ID_EXE = '0;
    logic [4:0]       instruction_IF_ID_Rs = '0;
    logic [4:0]       instruction_IF_ID_Rt = '0;
    logic             pc_src_EXE_MEM = 1'b0;
    logic             dmem_wait = 1'b0;
    logic             cnt_clear = 1'b0;
    logic             pc_write, if_id_write, id_exe_bubble;
    logic             if_id_flush, id_exe_flush, exe_mem_flush, pipe_freeze;
    logic [1:0]       hazard_state;
    logic [CNT_W-1:0] stall_count, flush_count;

    int checks   = 0;
    int failures = 0;
    int m_stall  = 0;
    int m_flush  = 0;

    vec_t exp_q[$];
    vec_t tbl[18];

    hazard_control_unit #(.CNT_W(CNT_W)) dut (
        .clk                  (clk),
        .arst                 (arst),
        .mem_read_ID_EXE      (mem_read_ID_EXE),
        .regfile_waddr_ID_EXE (regfile_waddr_ID_EXE),
        .instruction_IF_ID_Rs (instruction_IF_ID_Rs),
        .instruction_IF_ID_Rt (instruction_IF_ID_Rt),
        .pc_src_EXE_MEM       (pc_src_EXE_MEM),
        .dmem_wait            (dmem_wait),
        .cnt_clear            (cnt_clear),
        .pc_write             (pc_write),
        .if_id_write          (if_id_write),
        .id_exe_bubble        (id_exe_bubble),
        .if_id_flush          (if_id_flush),
        .id_exe_flush         (id_exe_flush),
        .exe_mem_flush        (exe_mem_flush),
        .pipe_freeze          (pipe_freeze),
        .hazard_state         (hazard_state),
        .stall_count          (stall_count),
        .flush_count          (flush_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic mr, input int wa, input int rs, input int rt,
                                input logic pcsrc, input logic dw, input logic clr,
                                input logic pcw, input logic ifw, input logic bub,
                                input logic fl, input logic frz, input int st);
        vec_t v;
        v.mr = mr; v.waddr = 5'(wa); v.rs = 5'(rs); v.rt = 5'(rt);
        v.pcsrc = pcsrc; v.dw = dw; v.clr = clr;
        v.e_pcw = pcw; v.e_ifw = ifw; v.e_bub = bub;
        v.e_fl = fl; v.e_frz = frz; v.e_st = 2'(st);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        @(posedge clk);
        #1;
        mem_read_ID_EXE      = v.mr;
        regfile_waddr_ID_EXE = v.waddr;
        instruction_IF_ID_Rs = v.rs;
        instruction_IF_ID_Rt = v.rt;
        pc_src_EXE_MEM       = v.pcsrc;
        dmem_wait            = v.dw;
        cnt_clear            = v.clr;
        exp_q.push_back(v);
        @(negedge clk);
    endtask

    // Monitor: compare on the falling edge, then advance the counter model
    // for the rising edge that follows.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            vec_t e;
            e = exp_q.pop_front();
            check("pc_write",      int'(pc_write),      int'(e.e_pcw));
            check("if_id_write",   int'(if_id_write),   int'(e.e_ifw));
            check("id_exe_bubble", int'(id_exe_bubble), int'(e.e_bub));
            check("if_id_flush",   int'(if_id_flush),   int'(e.e_fl));
            check("id_exe_flush",  int'(id_exe_flush),  int'(e.e_fl));
            check("exe_mem_flush", int'(exe_mem_flush), int'(e.e_fl));
            check("pipe_freeze",   int'(pipe_freeze),   int'(e.e_frz));
            check("hazard_state",  int'(hazard_state),  int'(e.e_st));
            check("stall_count",   int'(stall_count),   m_stall);
            check("flush_count",   int'(flush_count),   m_flush);
            if (e.clr) begin
                m_stall = 0;
                m_flush = 0;
            end else begin
                if ((e.e_bub || e.e_frz) && m_stall < CNT_SAT) m_stall++;
                if (e.e_fl && m_flush < CNT_SAT) m_flush++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          mr wa rs rt pc dw clr  pcw ifw bub fl frz st
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0); // idle
        tbl[1]  = mk(1, 5, 5, 2, 0, 0, 0,  0, 0, 1, 0, 0, 0); // load r5, Rs=5
        tbl[2]  = mk(1, 5, 5, 2, 0, 0, 0,  1, 1, 0, 0, 0, 1); // masked in STALL
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0);
        tbl[4]  = mk(1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0); // load r0: no hazard
        tbl[5]  = mk(1, 7, 3, 7, 0, 0, 0,  0, 0, 1, 0, 0, 0); // match on Rt
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 1);
        tbl[7]  = mk(1, 9, 9, 1, 1, 0, 0,  1, 1, 0, 1, 0, 0); // branch beats LU
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0);
        tbl[9]  = mk(0, 9, 9, 9, 0, 0, 0,  1, 1, 0, 0, 0, 0); // not a load
        tbl[10] = mk(0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 1, 0); // freeze beats branch
        tbl[11] = mk(0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 1, 2);
        tbl[12] = mk(0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 1, 2);
        tbl[13] = mk(0, 0, 0, 0, 1, 0, 0,  1, 1, 0, 1, 0, 2); // flush after wait drops
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0);
        tbl[15] = mk(1, 4, 4, 4, 0, 1, 0,  0, 0, 0, 0, 1, 0); // freeze beats LU
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 1,  1, 1, 0, 0, 0, 2); // clear
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0);

        // Reset state.
        #12;
        check("rst_pc_write",    int'(pc_write),      0);
        check("rst_if_id_write", int'(if_id_write),   0);
        check("rst_bubble",      int'(id_exe_bubble), 0);
        check("rst_flush",       int'(exe_mem_flush), 0);
        check("rst_freeze",      int'(pipe_freeze),   0);
        check("rst_state",       int'(hazard_state),  0);
        check("rst_stall_count", int'(stall_count),   0);
        check("rst_flush_count", int'(flush_count),   0);
        @(negedge clk);
        arst = 1'b0;

        for (int i = 0; i < 18; i++) drive(tbl[i]);

        // Saturation: 20 freeze cycles on a 4-bit counter, then clear.
        for (int i = 0; i < 20; i++)
            drive(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, (i == 0) ? 0 : 2));
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 2));
        check("sat_stall_count", int'(stall_count), 15);
        drive(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0));
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        check("clr_stall_count", int'(stall_count), 0);

        // Asynchronous reset while in STALL.
        drive(mk(1, 6, 6, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        @(posedge clk);
        #2;
        mem_read_ID_EXE = 1'b0;
        check("pre_arst_state", int'(hazard_state), 1);
        check("pre_arst_stall", int'(stall_count),  1);
        #1 arst = 1'b1;
        #1;
        check("arst_state",       int'(hazard_state), 0);
        check("arst_stall_count", int'(stall_count),  0);
        check("arst_flush_count", int'(flush_count),  0);
        check("arst_pc_write",    int'(pc_write),     0);
        check("arst_if_id_write", int'(if_id_write),  0);
        @(negedge clk);
        arst = 1'b0;
        m_stall = 0;
        m_flush = 0;

        // First edges after reset evaluate from RUN.
        drive(mk(1, 6, 6, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        drive(mk(1, 6, 6, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1));
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameter CNT_W, default 16: width of the stall and flush performance counters.
REQ-002 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 arst  input  1  reset; asynchronous, active-high.
REQ-004 mem_read_ID_EXE  input  1  instruction in ID/EXE is a load.
REQ-005 regfile_waddr_ID_EXE  input  5  destination register of the ID/EXE instruction.
REQ-006 instruction_IF_ID_Rs  input  5  Rs field of the instruction in IF/ID.
REQ-007 instruction_IF_ID_Rt  input  5  Rt field of the instruction in IF/ID.
REQ-008 pc_src_EXE_MEM  input  1  branch/jump taken, resolved in EXE/MEM.
REQ-009 dmem_wait  input  1  data memory not ready; whole pipeline must hold.
REQ-010 cnt_clear  input  1  synchronous clear of both counters.
REQ-011 pc_write  output  1  PC register write enable.
REQ-012 if_id_write  output  1  IF/ID register write enable.
REQ-013 id_exe_bubble  output  1  load zeroed control into ID/EXE (bubble).
REQ-014 if_id_flush, id_exe_flush, exe_mem_flush  output  1 each  squash the named pipeline register.
REQ-015 pipe_freeze  output  1  hold ID/EXE, EXE/MEM and MEM/WB.
REQ-016 hazard_state  output  2  current FSM state: 00 RUN, 01 STALL, 10 FREEZE.
REQ-017 stall_count, flush_count  output  CNT_W each  saturating event counters.

Function
REQ-018 Load-use hazard (LU) SHALL be: mem_read_ID_EXE=1 and regfile_waddr_ID_EXE!=0 and waddr equals Rs or Rt of IF/ID.
REQ-019 Priority SHALL be dmem_wait > pc_src_EXE_MEM > LU > none, evaluated combinationally each cycle.
REQ-020 dmem_wait=1: pipe_freeze=1, pc_write=0, if_id_write=0; all flush and bubble outputs 0.
REQ-021 pc_src_EXE_MEM=1 (no dmem_wait): if_id_flush=id_exe_flush=exe_mem_flush=1, pc_write=1, if_id_write=1, id_exe_bubble=0; LU is ignored.
REQ-022 LU (no higher event) with state RUN: pc_write=0, if_id_write=0, id_exe_bubble=1.
REQ-023 LU with state STALL SHALL be masked (no second consecutive stall for the same instruction); outputs as idle.
REQ-024 Idle: pc_write=1, if_id_write=1, all other control outputs 0.
REQ-025 FSM: RUN->STALL on LU-stall cycle; STALL->RUN unconditionally unless dmem_wait; any state->FREEZE when dmem_wait=1; FREEZE->RUN when dmem_wait=0.
REQ-026 All control outputs SHALL be zero-latency combinational functions of inputs and current state.
REQ-027 stall_count SHALL increment by 1 on every clock edge where id_exe_bubble=1 or pipe_freeze=1.
REQ-028 flush_count SHALL increment by 1 on every clock edge where exe_mem_flush=1.
REQ-029 Counters SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-030 cnt_clear=1 SHALL zero both counters on the next edge, taking precedence over an increment in that cycle; FSM unaffected.

Reset
REQ-031 While arst=1: state RUN, stall_count=0, flush_count=0, pc_write=0, if_id_write=0, all flush/bubble/freeze outputs 0.
REQ-032 Reset assertion mid-STALL or mid-FREEZE SHALL return the FSM to RUN immediately and asynchronously.
REQ-033 After arst deasserts, the first edge SHALL evaluate normally from state RUN.

Verification
REQ-034 Load r5 in ID/EXE, IF/ID Rs=5 -> one cycle pc_write=0, if_id_write=0, id_exe_bubble=1, state 01; next cycle idle, stall_count=1.
REQ-035 Load r0 in ID/EXE, Rs=0 -> no stall, pc_write=1, stall_count stays 0.
REQ-036 pc_src_EXE_MEM=1 together with LU -> three flushes=1, id_exe_bubble=0, flush_count=1, stall_count unchanged.
REQ-037 dmem_wait=1 for 3 cycles with pc_src_EXE_MEM=1 -> freeze 3 cycles, no flush; state 10; flush fires on the cycle after dmem_wait drops; stall_count=3, flush_count=1.
REQ-038 With CNT_W=4, 20 freeze cycles -> stall_count holds 15; cnt_clear for one cycle -> 0.
REQ-039 arst pulse asserted while state=STALL -> state 00 and counters 0 without a clock edge.
